// File: rtl/sru_pkg.sv
// Shared definitions for the store read-modify-write path: access sizes
// (same encoding as the load path), FSM states and request legality.
package sru_pkg;

  localparam int ADDR_W = 32;

  localparam logic [1:0] W = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } sru_state_t;

  // Illegal size, or an access that is not naturally aligned for its size.
  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) || ((size == H) && lane[0]) || ((size == W) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request-side and memory-side signals of the store read-modify-write unit.
// Handshakes: the requester raises req and holds it until it sees the one-cycle
// done pulse (req is sampled only while idle). Towards memory, rd or wr stays
// high with stable mem_addr/mem_wdata until a cycle in which ack is high;
// that cycle completes the access. ack is ignored while no strobe is high.
interface store_rmw_unit_if;
  import sru_pkg::*;

  logic              I_SRU_req;
  logic [ADDR_W-1:0] I_SRU_addr;
  logic [31:0]       I_SRU_data;
  logic [1:0]        I_SRU_size;
  logic              O_SRU_busy;
  logic              O_SRU_done;
  logic              O_SRU_err;
  logic [ADDR_W-1:0] O_SRU_mem_addr;
  logic              O_SRU_mem_rd;
  logic              O_SRU_mem_wr;
  logic [31:0]       O_SRU_mem_wdata;
  logic [31:0]       I_SRU_mem_rdata;
  logic              I_SRU_mem_ack;
  sru_state_t        state_dbg;

  modport slave (
    input  I_SRU_req, I_SRU_addr, I_SRU_data, I_SRU_size, I_SRU_mem_rdata, I_SRU_mem_ack,
    output O_SRU_busy, O_SRU_done, O_SRU_err, O_SRU_mem_addr, O_SRU_mem_rd,
           O_SRU_mem_wr, O_SRU_mem_wdata, state_dbg
  );

  modport master (
    output I_SRU_req, I_SRU_addr, I_SRU_data, I_SRU_size, I_SRU_mem_rdata, I_SRU_mem_ack,
    input  O_SRU_busy, O_SRU_done, O_SRU_err, O_SRU_mem_addr, O_SRU_mem_rd,
           O_SRU_mem_wr, O_SRU_mem_wdata, state_dbg
  );

endinterface

// File: rtl/store_lane_merge.sv
// Replaces the addressed little-endian byte/halfword lane of an old memory
// word with right-justified store data; word size passes the data through.
module store_lane_merge
  import sru_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      W:       merged = data;
      H:       merged[{lane[1], 4'b0000} +: 16] = data[15:0];
      B:       merged[{lane, 3'b000} +: 8] = data[7:0];
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-only data memory: word stores write directly,
// halfword/byte stores read the word, merge the lane(s) and write it back.
module store_rmw_unit
  import sru_pkg::*;
(
  input  logic           I_SRU_clk,
  input  logic           I_SRU_rst_n,
  store_rmw_unit_if.slave bus
);

  sru_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       word_q;
  logic [31:0]       merged;
  logic [1:0]        size_q;
  logic              err_q;
  logic              take_req;
  logic              take_rd;
  logic              req_bad;

  assign req_bad = bad_req(bus.I_SRU_size, bus.I_SRU_addr[1:0]);

  store_lane_merge u_merge (
    .old_word (bus.I_SRU_mem_rdata),
    .data     (data_q),
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .merged   (merged)
  );

  always_comb begin
    state_nxt = state;
    take_req  = 1'b0;
    take_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.I_SRU_req) begin
          take_req = 1'b1;
          if (req_bad)                 state_nxt = DONE;
          else if (bus.I_SRU_size == W) state_nxt = WRITE;
          else                         state_nxt = READ;
        end
      end
      READ: begin
        if (bus.I_SRU_mem_ack) begin
          take_rd   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE:   if (bus.I_SRU_mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_SRU_clk or negedge I_SRU_rst_n) begin
    if (!I_SRU_rst_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // word_q doubles as the direct write data for word stores.
  always_ff @(posedge I_SRU_clk or negedge I_SRU_rst_n) begin
    if (!I_SRU_rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      err_q  <= 1'b0;
      word_q <= '0;
    end else begin
      if (take_req) begin
        addr_q <= bus.I_SRU_addr;
        data_q <= bus.I_SRU_data;
        size_q <= bus.I_SRU_size;
        err_q  <= req_bad;
        word_q <= bus.I_SRU_data;
      end
      if (take_rd) word_q <= merged;
    end
  end

  assign bus.O_SRU_busy      = (state != IDLE);
  assign bus.O_SRU_done      = (state == DONE);
  assign bus.O_SRU_err       = (state == DONE) && err_q;
  assign bus.O_SRU_mem_rd    = (state == READ);
  assign bus.O_SRU_mem_wr    = (state == WRITE);
  assign bus.O_SRU_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.O_SRU_mem_wdata = word_q;
  assign bus.state_dbg       = state;

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Store-path counterpart of the load truncator/extender. Accepts a store request (word, halfword or byte, same size encoding as the load path) from the MEM stage. It writes the data into a word-only data memory. Word stores go straight to memory; halfword and byte stores do a read-modify-write so the untouched byte lanes are preserved. Sits between the MEM-stage store logic and the data memory port; the pipeline stalls on `O_SRU_busy`.

## Interface
- `ADDR_W`, 32, byte-address width; memory address output is word-aligned (`[1:0]` forced to 0).
- `I_SRU_clk`  in  1  clock, all state on rising edge.
- `I_SRU_rst_n`  in  1  asynchronous, active-low reset.
- `I_SRU_req`  in  1  store request, sampled only in IDLE.
- `I_SRU_addr`  in  ADDR_W  byte address of the store.
- `I_SRU_data`  in  32  store data, right-justified (byte in `[7:0]`, half in `[15:0]`).
- `I_SRU_size`  in  2  00 = W, 01 = H, 10 = B, 11 = illegal.
- `O_SRU_busy`  out  1  high whenever state ≠ IDLE.
- `O_SRU_done`  out  1  one-cycle pulse at completion (success or error).
- `O_SRU_err`  out  1  one-cycle pulse coincident with `done` for a misaligned or illegal-size request.
- `O_SRU_mem_addr`  out  ADDR_W  word address `{addr[ADDR_W-1:2],2'b00}`.
- `O_SRU_mem_rd`  out  1  memory read strobe.
- `O_SRU_mem_wr`  out  1  memory write strobe.
- `O_SRU_mem_wdata`  out  32  full word to write.
- `I_SRU_mem_rdata`  in  32  read data, valid when `ack` is high with `rd` asserted.
- `I_SRU_mem_ack`  in  1  memory completes the current rd/wr; ignored when neither is asserted.

## Operation
- Little-endian lanes: byte k = bits `[8k+7:8k]`, k = `addr[1:0]`; halfword at `addr[1]` = bits `[16·addr[1]+15 : 16·addr[1]]`.
- FSM states: IDLE, READ, WRITE, DONE.
- **IDLE**
  - On `req`, latch addr, data and size.
  - Illegal size (11), H with `addr[0]=1`, or W with `addr[1:0]≠0` → DONE with err flag set, no memory access.
  - W → WRITE with wdata = data.
  - H or B → READ.
- **READ**
  - `mem_rd=1` and hold until `ack`.
  - On `ack`, register the merged word: rdata with the addressed lane(s) replaced by data, then → WRITE.
- **WRITE**
  - `mem_wr=1`, wdata = registered word; hold until `ack`.
  - On `ack` → DONE.
- **DONE**
  - `done=1`, plus `err=1` if the err flag is set; → IDLE unconditionally.
- `req` while busy is ignored, not queued. The requester holds `req` until it sees `done`.
- `rd` and `wr` are never high together. `mem_addr` and `wdata` are stable while the strobe is high.

## Timing
- Reset (asynchronous, any state): state = IDLE. All outputs 0: busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata. Latched request and err flag cleared. An in-flight memory access is abandoned.
- `ack` may arrive in the first cycle a strobe is high (zero wait).
- Word store, zero wait: req at cycle 0; WRITE at cycle 1; DONE at cycle 2; IDLE at cycle 3, where a new request can be accepted.
- H/B store, zero wait: READ at cycle 1, WRITE at cycle 2, DONE at cycle 3.
- Each wait cycle adds exactly one cycle.
- Error path: DONE at cycle 1 with `err=1`; no strobe is ever asserted.
- `ack` in IDLE or DONE has no effect.

## Structure
- Shared package `sru_pkg`:
  - size localparams W=2'b00, H=2'b01, B=2'b10, matching the load path;
  - state encoding IDLE/READ/WRITE/DONE.
- One combinational sub-module `store_lane_merge`. Inputs: old word, store data, size, `addr[1:0]`. Output: merged word. Used at READ→WRITE.

## Test plan
- Memory[0x100]=0x11223344; SB addr 0x101 data 0x000000AA, ack tied 1 → rd@c1, wr@c2 with wdata 0x1122AA44 to 0x100, done@c3.
- Same word; SH addr 0x102 data 0x0000BEEF, ack delayed 2 cycles on each access → wdata 0xBEEF3344; done 4 cycles later than the zero-wait case; busy high throughout.
- SW addr 0x104 data 0xDEADBEEF, ack tied 1 → no rd; wr@c1 with wdata 0xDEADBEEF to 0x104; done@c2.
- SH addr 0x103, SW addr 0x106, and size 11 → done=err=1 at c1; rd and wr never asserted.
- Second req pulsed while busy → ignored, exactly one write and one done observed.
- Reset asserted mid-WRITE with ack held low → all outputs 0 immediately. A fresh SB after reset release completes normally.
